// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;

  // The state encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W           = 16;

  function automatic logic [1:0] state_to_grant(input state_t s);
    case (s)
      ST_OWN0: return GRANT_M0;
      ST_OWN1: return GRANT_M1;
      default: return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Slave-wait counter: held at zero while clear is high, counts enabled cycles,
// flags when the count equals TIMEOUT.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master to one-slave arbiter; requests pass through combinationally to the
// owner, with a forced completion when the slave stalls for TIMEOUT cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter bit RR_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_grant;
  logic       r_last_m1;
  logic       w_own;
  logic       w_own_valid;
  logic       w_expired;
  logic       w_timeout;
  logic       w_done;

  assign w_own       = (r_state != ST_IDLE);
  assign w_own_valid = (r_state == ST_OWN0) ? m0_valid :
                       (r_state == ST_OWN1) ? m1_valid : 1'b0;
  assign w_timeout   = w_own_valid & ~s_ready & w_expired;
  // A dropped valid is an abort and never updates the round-robin pointer.
  assign w_done      = w_own_valid & (s_ready | w_expired);

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (~w_own),
    .i_enable  (w_own & ~s_ready),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= GRANT_NONE;
      r_last_m1 <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= state_to_grant(w_state_nxt);
      if (w_done) begin
        r_last_m1 <= (r_state == ST_OWN1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (m0_valid && m1_valid) begin
          if (RR_EN) begin
            w_state_nxt = r_last_m1 ? ST_OWN0 : ST_OWN1;
          end else begin
            w_state_nxt = ST_OWN0;
          end
        end else if (m0_valid) begin
          w_state_nxt = ST_OWN0;
        end else if (m1_valid) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!w_own_valid || s_ready || w_expired) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m0_rdata    = '0;
    m1_ready    = 1'b0;
    m1_rdata    = '0;
    timeout_err = w_timeout;
    case (r_state)
      ST_OWN0: begin
        s_valid  = m0_valid & ~w_timeout;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready | w_timeout;
        m0_rdata = w_timeout ? 32'h0 : s_rdata;
      end
      ST_OWN1: begin
        s_valid  = m1_valid & ~w_timeout;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready | w_timeout;
        m1_rdata = w_timeout ? 32'h0 : s_rdata;
      end
      default: ;
    endcase
  end

  assign grant = r_grant;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench driving a round-robin and a fixed-priority arbiter from shared stimulus.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m1_valid, s_ready;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic        rr_m0_ready, rr_m1_ready, rr_s_valid, rr_timeout_err;
  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_s_addr, rr_s_wdata;
  logic [3:0]  rr_s_wstrb;
  logic [1:0]  rr_grant;

  logic        fp_m0_ready, fp_m1_ready, fp_s_valid, fp_timeout_err;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
  logic [3:0]  fp_s_wstrb;
  logic [1:0]  fp_grant;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(rr_m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(rr_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(rr_m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(rr_m1_rdata),
    .s_valid(rr_s_valid), .s_addr(rr_s_addr), .s_wdata(rr_s_wdata), .s_wstrb(rr_s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .grant(rr_grant), .timeout_err(rr_timeout_err)
  );

  mem_arbiter #(.TIMEOUT(4), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_ready(fp_m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_ready(fp_m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(fp_m1_rdata),
    .s_valid(fp_s_valid), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .grant(fp_grant), .timeout_err(fp_timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] exp_a;

    reset    = 1'b1;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata = '0;

    #2;
    chk("reset_grant", rr_grant, 2'b00);
    chk("reset_s_valid", rr_s_valid, 1'b0);
    chk("reset_ready", {rr_m0_ready, rr_m1_ready}, 2'b00);
    chk("reset_timeout_err", rr_timeout_err, 1'b0);
    #10;
    reset = 1'b0;

    // Single m0 read, slave answers on the third owned cycle.
    step();
    m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
    s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
    #1;
    chk("idle_grant", rr_grant, 2'b00);
    chk("idle_s_valid", rr_s_valid, 1'b0);
    chk("idle_s_addr", rr_s_addr, 32'h0);
    chk("idle_sready_ignored", rr_m0_ready, 1'b0);
    s_ready = 1'b0;
    step();
    #1;
    chk("rd_grant", rr_grant, 2'b01);
    chk("rd_s_valid", rr_s_valid, 1'b1);
    chk("rd_s_addr", rr_s_addr, 32'h0000_0100);
    chk("rd_s_wstrb", rr_s_wstrb, 4'h0);
    chk("rd_wait_ready", rr_m0_ready, 1'b0);
    step();
    #1;
    chk("rd_wait2_ready", rr_m0_ready, 1'b0);
    step();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    chk("rd_m0_ready", rr_m0_ready, 1'b1);
    chk("rd_m0_rdata", rr_m0_rdata, 32'h1234_5678);
    chk("rd_m1_ready", rr_m1_ready, 1'b0);
    chk("rd_m1_rdata", rr_m1_rdata, 32'h0);
    chk("rd_no_timeout", rr_timeout_err, 1'b0);
    step();
    #1;
    chk("rd_back_idle", rr_grant, 2'b00);
    chk("rd_idle_ready", rr_m0_ready, 1'b0);
    m0_valid = 1'b0; s_ready = 1'b0;

    // Both masters held valid, slave always ready.
    pulse_reset();
    m0_valid = 1'b1; m0_addr = 32'h0000_0100;
    m1_valid = 1'b1; m1_addr = 32'h0000_0200;
    s_ready = 1'b1; s_rdata = 32'hA5A5_0000;
    for (int i = 0; i < 16; i++) begin
      step();
      #1;
      exp_g = (i % 2 != 0) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
      exp_a = (exp_g == 2'b01) ? 32'h0000_0100 : (exp_g == 2'b10) ? 32'h0000_0200 : 32'h0;
      chk("rr_grant", rr_grant, exp_g);
      chk("rr_m0_ready", rr_m0_ready, exp_g[0]);
      chk("rr_m1_ready", rr_m1_ready, exp_g[1]);
      chk("rr_s_addr", rr_s_addr, exp_a);
      chk("fp_grant", fp_grant, (i % 2 != 0) ? 2'b00 : 2'b01);
      chk("fp_m1_ready", fp_m1_ready, 1'b0);
    end
    m0_valid = 1'b0;
    step();
    #1;
    chk("fp_m1_served", fp_grant, 2'b10);
    chk("rr_m1_alone", rr_grant, 2'b10);
    chk("fp_m1_ready_done", fp_m1_ready, 1'b1);
    m1_valid = 1'b0; s_ready = 1'b0;
    step();
    #1;
    chk("post_rr_idle", rr_grant, 2'b00);

    // m1 write with a stalled slave forces a timeout completion.
    pulse_reset();
    m1_valid = 1'b1; m1_addr = 32'h8000_0000; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF;
    s_rdata = 32'hDEAD_BEEF;
    step();
    #1;
    chk("to_grant", rr_grant, 2'b10);
    chk("to_s_addr", rr_s_addr, 32'h8000_0000);
    chk("to_s_wdata", rr_s_wdata, 32'hCAFE_F00D);
    chk("to_s_wstrb", rr_s_wstrb, 4'hF);
    for (int i = 2; i <= 4; i++) begin
      step();
      #1;
      chk("to_wait_ready", rr_m1_ready, 1'b0);
      chk("to_wait_err", rr_timeout_err, 1'b0);
    end
    step();
    #1;
    chk("to_m1_ready", rr_m1_ready, 1'b1);
    chk("to_m1_rdata", rr_m1_rdata, 32'h0);
    chk("to_s_valid", rr_s_valid, 1'b0);
    chk("to_err", rr_timeout_err, 1'b1);
    chk("to_err_fp", fp_timeout_err, 1'b1);
    step();
    #1;
    chk("to_idle", rr_grant, 2'b00);
    chk("to_err_single", rr_timeout_err, 1'b0);
    chk("to_idle_ready", rr_m1_ready, 1'b0);

    // s_ready arriving exactly on the expiry cycle completes normally.
    step();
    #1;
    chk("edge_grant", rr_grant, 2'b10);
    for (int i = 2; i <= 4; i++) begin
      step();
      #1;
      chk("edge_wait_ready", rr_m1_ready, 1'b0);
    end
    step();
    s_ready = 1'b1;
    #1;
    chk("edge_m1_ready", rr_m1_ready, 1'b1);
    chk("edge_m1_rdata", rr_m1_rdata, 32'hDEAD_BEEF);
    chk("edge_no_err", rr_timeout_err, 1'b0);
    chk("edge_s_valid", rr_s_valid, 1'b1);
    step();
    #1;
    chk("edge_idle", rr_grant, 2'b00);
    m1_valid = 1'b0; s_ready = 1'b0;

    // m0 abort must not move the round-robin pointer (last completion was m1).
    m0_valid = 1'b1;
    step();
    #1;
    chk("ab_grant", rr_grant, 2'b01);
    m0_valid = 1'b0;
    #1;
    chk("ab_s_valid", rr_s_valid, 1'b0);
    chk("ab_ready", rr_m0_ready, 1'b0);
    step();
    #1;
    chk("ab_idle", rr_grant, 2'b00);
    chk("ab_no_err", rr_timeout_err, 1'b0);
    m0_valid = 1'b1; m1_valid = 1'b1;
    step();
    #1;
    chk("ab_rr_next_m0", rr_grant, 2'b01);
    m0_valid = 1'b0; m1_valid = 1'b0;
    step();
    #1;
    chk("ab2_idle", rr_grant, 2'b00);

    // Reset asserted between edges while m0 owns the slave.
    m0_valid = 1'b1;
    step();
    #1;
    chk("mr_grant", rr_grant, 2'b01);
    m1_valid = 1'b1;
    reset = 1'b1;
    #1;
    s_ready = 1'b1;
    #1;
    chk("mr_grant_now", rr_grant, 2'b00);
    chk("mr_s_valid", rr_s_valid, 1'b0);
    chk("mr_m0_ready", rr_m0_ready, 1'b0);
    chk("mr_fp_grant", fp_grant, 2'b00);
    reset = 1'b0;
    s_ready = 1'b0;
    m0_valid = 1'b0;
    step();
    #1;
    chk("mr_m1_first", rr_grant, 2'b10);
    chk("mr_m1_first_fp", fp_grant, 2'b10);
    chk("mr_m1_s_addr", rr_s_addr, 32'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, slave-wait cycles before forced completion (1..65535).
REQ-002 Parameter: RR_EN, default 1, 1 = round-robin, 0 = fixed priority m0 > m1.
REQ-003 Port: clk  in  1  single clock, all logic on rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: m0_valid / m0_ready  in / out  1 / 1  master 0 (CPU) request / completion.
REQ-006 Port: m0_addr, m0_wdata  in  32 each  master 0 address, write data.
REQ-007 Port: m0_wstrb  in  4  master 0 byte strobes, 0 = read.
REQ-008 Port: m0_rdata  out  32  master 0 read data.
REQ-009 Port: m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata  as REQ-005..008  master 1 (DMA/loader).
REQ-010 Port: s_valid, s_addr, s_wdata, s_wstrb  out  1/32/32/4  shared slave request (RAM banks, UART, LED decode).
REQ-011 Port: s_ready, s_rdata  in  1/32  slave completion, read data.
REQ-012 Port: grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1.
REQ-013 Port: timeout_err  out  1  one-cycle pulse on forced completion.

Function
REQ-014 FSM states IDLE, OWN0, OWN1; state and grant registered.
REQ-015 IDLE: only m0_valid -> OWN0; only m1_valid -> OWN1; none -> stay IDLE.
REQ-016 IDLE, both valid, RR_EN=1: grant master not last granted; RR_EN=0: grant m0.
REQ-017 Latency: valid seen in IDLE at cycle N, grant/s_valid high at N+1.
REQ-018 OWNx: s_valid = mx_valid; s_addr/s_wdata/s_wstrb = owner's signals; mx_ready = s_ready; mx_rdata = s_rdata; all combinational.
REQ-019 Non-owner: ready 0, rdata 0.
REQ-020 IDLE: s_valid 0, s_addr/s_wdata 0, s_wstrb 0.
REQ-021 OWNx with s_ready=1 -> IDLE next cycle; last_grant <= x.
REQ-022 One IDLE cycle between transactions guaranteed; a master holding valid after ready is re-arbitrated, never double-completed.
REQ-023 Owner drops valid before s_ready (abort) -> IDLE next cycle; last_grant unchanged; no error.
REQ-024 Wait counter 16 bits; cleared on entering OWNx; +1 each OWNx cycle with s_ready=0.
REQ-025 Counter == TIMEOUT while s_ready=0 -> that cycle: mx_ready=1, mx_rdata=0, s_valid=0, timeout_err=1; next cycle IDLE; last_grant <= x.
REQ-026 s_ready in the counter==TIMEOUT cycle -> normal completion, no error (s_ready wins).
REQ-027 s_ready while IDLE is ignored; no master sees ready.
REQ-028 Request fields are never latched; slave sees live owner values.

Reset
REQ-029 Async reset asserted: state IDLE, grant 00, s_valid 0, m0/m1_ready 0, timeout_err 0, counter 0, last_grant = m1 (first contested grant to m0), immediately and independent of clk.
REQ-030 Reset mid-transaction abandons it; no ready pulse to the owner.
REQ-031 Release: first grant no earlier than the cycle after the first rising edge with reset low.

Structure
REQ-032 Package mem_arb_pkg: state encoding (IDLE/OWN0/OWN1), grant one-hot constants, TIMEOUT default, counter width 16.
REQ-033 Sub-module mem_arb_timer holds the wait counter and compare; inputs clear/enable, output expired.
REQ-034 No other hierarchy; request mux inline.

Verification
REQ-035 m0 read 0x0000_0100, s_ready 2 cycles after s_valid, s_rdata 0x1234_5678 -> m0_rdata 0x1234_5678, m0_ready one cycle, grant 01, m1_ready 0.
REQ-036 m0, m1 valid same cycle, 4 back-to-back each, RR_EN=1 -> order m0,m1,m0,m1,... with one IDLE cycle between grants.
REQ-037 Same, RR_EN=0, m0 held valid -> m0 served every transaction; m1 only when m0_valid low in IDLE.
REQ-038 TIMEOUT=4, m1 write 0x8000_0000 strobe 0xF, s_ready held 0 -> 5th owned cycle m1_ready=1, m1_rdata 0, timeout_err one pulse, then IDLE.
REQ-039 TIMEOUT=4, s_ready exactly in counter==4 cycle -> normal completion, timeout_err stays 0.
REQ-040 reset asserted mid-OWN0 between edges -> s_valid, grant, m0_ready 0 immediately; after release, pending m1 granted first available cycle.
